ps2_key_code_tracker: RTL
=========================

Name: ps2_key_code_tracker

Overview:
- Sits between the PS/2 receive controller and the bank of hex-to-seven-segment converters on the keyboard path.
- Consumes raw received bytes and decodes PS/2 Set-2 make/break/extended sequences with a 4-state FSM.
- Keeps a 4-byte raw history and a current-key register.
- Exposes 8 hex nibbles for direct connection to eight seven-segment converters, plus key status.

Parameters:
- TIMEOUT_CYCLES, 50000000, cycles a partial prefix sequence (E0/F0) may wait for its next byte before the FSM abandons it.
- TIMEOUT_W, 26, width of the timeout counter; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- reset  input  1  asynchronous, active-high reset.
- received_data  input  8  byte from PS/2 receiver; valid only when received_data_en=1.
- received_data_en  input  1  one-cycle strobe per received byte.
- clear_history  input  1  synchronous clear of history and make_count.
- hex_digits  output  32  raw history {byte3,byte2,byte1,byte0}; byte0 is newest; nibble k = hex_digits[4k+3:4k].
- key_code  output  8  code of last completed make.
- key_extended  output  1  last make was E0-prefixed.
- key_pressed  output  1  last made key still held.
- key_event  output  1  one-cycle pulse on every completed make or matching break.
- make_count  output  8  count of completed makes, wraps 255->0.

Behaviour:
- Clock/reset: one clock (clk); reset asynchronous, active-high; all state in the clk domain.
- Reset values: all outputs 0, FSM=IDLE, timeout counter 0.
- History:
  - On received_data_en, shift left by a byte: byte3<=byte2, byte2<=byte1, byte1<=byte0, byte0<=received_data.
  - Every byte is shifted in, including prefixes and non-key bytes.
  - Visible on hex_digits the cycle after the strobe (1-cycle latency).
- FSM states: IDLE, EXT, BRK, EXT_BRK. Transitions occur only on received_data_en.
  - IDLE: E0->EXT; F0->BRK; FA/AA/EE/FE/00/FF->IDLE with no key update; any other byte is a make (extended=0).
  - EXT: F0->EXT_BRK; E0->EXT; any other byte is a make (extended=1).
  - BRK: any byte except E0/F0 is a break (extended=0), then IDLE; E0 or F0 -> IDLE (malformed, discarded).
  - EXT_BRK: any byte except E0/F0 is a break (extended=1), then IDLE; E0/F0 -> IDLE.
- Make completion (registered, 1 cycle after strobe):
  - key_code<=byte; key_extended<=ext; key_pressed<=1; make_count<=make_count+1 mod 256; key_event=1 for one cycle; FSM->IDLE.
  - Typematic repeats of the same make count as makes.
- Break completion:
  - If byte==key_code and ext==key_extended and key_pressed=1: key_pressed<=0, key_event=1.
  - Otherwise no key/status change and no key_event. FSM->IDLE either way.
- Timeout:
  - Counter clears on every strobe and whenever FSM=IDLE.
  - While FSM≠IDLE with no strobe, it increments.
  - When it reaches TIMEOUT_CYCLES-1, the FSM goes to IDLE on the next edge. No output changes; history retained.
- clear_history:
  - hex_digits<=0 and make_count<=0; FSM, key_code, key_pressed unaffected.
  - Coinciding with a strobe: result is hex_digits={24'h0,byte}. A make completing in the same cycle gives make_count=1; FSM processes the byte normally.
- Reset mid-sequence (e.g. after E0): FSM immediately IDLE; the next byte is treated as unprefixed.
- received_data is ignored when received_data_en=0. Back-to-back strobes on consecutive cycles must be handled.

Test Plan:
- Reset, then strobe 1C -> next cycle key_code=1C, key_extended=0, key_pressed=1, key_event pulse, make_count=1, hex_digits=0000001C.
- Strobes E0,75,E0,F0,75 -> after 2nd byte key_code=75, key_extended=1, pressed=1; after 5th byte pressed=0; exactly 2 key_event pulses; hex_digits=75E0F075.
- Make 1C, then F0,32 -> key_pressed stays 1, no key_event on break; hex_digits=001CF032.
- TIMEOUT_CYCLES=16: strobe F0, idle 20 cycles, strobe 1C -> treated as make (pressed=1, make_count+1), not a break.
- 256 makes of 29 -> make_count wraps to 0; clear_history together with strobe 29 -> hex_digits=00000029, make_count=1.
- Strobe E0, assert reset 1 cycle, strobe 5A -> key_code=5A, key_extended=0.

Source files
------------

// File: rtl/ps2_key_code_tracker.sv
// PS/2 Set-2 key code tracker: decodes make/break/extended sequences from raw
// bytes, keeps a 4-byte raw history for hex display and tracks the current key.
module ps2_key_code_tracker #(
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int unsigned TIMEOUT_W      = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  received_data,
  input  logic        received_data_en,
  input  logic        clear_history,
  output logic [31:0] hex_digits,
  output logic [7:0]  key_code,
  output logic        key_extended,
  output logic        key_pressed,
  output logic        key_event,
  output logic [7:0]  make_count
);

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

  localparam logic [TIMEOUT_W-1:0] TmoLast = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic [31:0]          hist_q;
  logic [7:0]           key_code_q;
  logic                 key_ext_q;
  logic                 key_pressed_q;
  logic                 key_event_q;
  logic [7:0]           make_count_q;

  logic is_e0, is_f0, is_ignored;
  logic make, brk, ext, brk_match;

  assign is_e0      = (received_data == 8'hE0);
  assign is_f0      = (received_data == 8'hF0);
  // Keyboard replies (ACK, BAT ok, echo, resend, errors) are not key codes.
  assign is_ignored = (received_data == 8'hFA) || (received_data == 8'hAA) ||
                      (received_data == 8'hEE) || (received_data == 8'hFE) ||
                      (received_data == 8'h00) || (received_data == 8'hFF);

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    make    = 1'b0;
    brk     = 1'b0;
    ext     = 1'b0;
    if (received_data_en) begin
      tmo_d = '0;
      unique case (state_q)
        StIdle: begin
          if (is_e0)           state_d = StExt;
          else if (is_f0)      state_d = StBrk;
          else if (!is_ignored) make   = 1'b1;
        end
        StExt: begin
          if (is_f0)      state_d = StExtBrk;
          else if (is_e0) state_d = StExt;
          else begin
            make    = 1'b1;
            ext     = 1'b1;
            state_d = StIdle;
          end
        end
        StBrk: begin
          state_d = StIdle;
          brk     = !(is_e0 || is_f0);
        end
        StExtBrk: begin
          state_d = StIdle;
          brk     = !(is_e0 || is_f0);
          ext     = 1'b1;
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q == StIdle) begin
      tmo_d = '0;
    end else if (tmo_q == TmoLast) begin
      state_d = StIdle;
      tmo_d   = '0;
    end else begin
      tmo_d = tmo_q + TIMEOUT_W'(1);
    end
  end

  assign brk_match = brk && (received_data == key_code_q) && (ext == key_ext_q) &&
                     key_pressed_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      tmo_q         <= '0;
      hist_q        <= '0;
      key_code_q    <= '0;
      key_ext_q     <= 1'b0;
      key_pressed_q <= 1'b0;
      key_event_q   <= 1'b0;
      make_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      key_event_q <= make || brk_match;

      if (received_data_en) begin
        hist_q <= clear_history ? {24'h0, received_data} : {hist_q[23:0], received_data};
      end else if (clear_history) begin
        hist_q <= '0;
      end

      if (make) begin
        key_code_q    <= received_data;
        key_ext_q     <= ext;
        key_pressed_q <= 1'b1;
        make_count_q  <= clear_history ? 8'd1 : make_count_q + 8'd1;
      end else begin
        if (clear_history) make_count_q <= '0;
        if (brk_match)     key_pressed_q <= 1'b0;
      end
    end
  end

  assign hex_digits   = hist_q;
  assign key_code     = key_code_q;
  assign key_extended = key_ext_q;
  assign key_pressed  = key_pressed_q;
  assign key_event    = key_event_q;
  assign make_count   = make_count_q;

endmodule
